spi_register_controller: RTL and testbench
==========================================

Name: spi_register_controller

Overview:
- SPI slave front-end that configures the synth's register file and exposes its output samples.
- Decodes SPI frames of a 16-bit register number followed by one or more 8-bit values, and issues single-cycle register writes (RegisterWriteEnable/Number/Value) to the synth core.
- Captures each completed output sample and shifts it out on MISO during the next frame.
- Replaces the direct parallel register-write port on the synth top level.

Parameters:
- SYNC_STAGES, 2: number of flip-flop synchroniser stages on SCLK, MOSI and CS_N (minimum 2).
- AUTO_INCREMENT, 1: 1 = each extra data byte in a frame writes register number +1; 0 = extra bytes rewrite the same register.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_SpiSclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to i_Clock, frequency at most i_Clock/8.
- i_SpiMosi  input  1  SPI data in, MSB first.
- i_SpiCs_n  input  1  SPI chip select, active low.
- o_SpiMiso  output  1  SPI data out, MSB first.
- i_Sample  input  16  signed sample from the synth core.
- i_SampleReady  input  1  one-cycle strobe; i_Sample is valid in that cycle.
- o_RegisterWriteEnable  output  1  one-cycle register write strobe.
- o_RegisterNumber  output  16  register number; valid while the write strobe is high.
- o_RegisterValue  output  8  register value; valid while the write strobe is high.
- o_FrameErrorCount  output  8  count of truncated frames; saturates at 8'hFF.

Behaviour:
- Reset (async assert, sync deassert): o_SpiMiso=0, o_RegisterWriteEnable=0, o_RegisterNumber=0, o_RegisterValue=0, o_FrameErrorCount=0, sample holding register=0, FSM=IDLE, armed flag=0.
- Synchronisation: SCLK, MOSI and CS_N each pass through SYNC_STAGES flops. SCLK rise/fall and CS_N fall/rise are detected by comparing the last two synchronised values.
- Armed flag: set whenever synchronised CS_N is high. A frame may start only when the armed flag is set, so a reset asserted mid-frame ignores the rest of that frame.
- Sample capture: on i_SampleReady, holding register <= i_Sample. This runs independently of the FSM.
- FSM states:
  - IDLE: on CS_N fall while armed, load the MISO shift register from the holding register, clear the bit counter and go to ADDRESS. If i_SampleReady is high in the same cycle, the previous held value is loaded (the holding register update lands one cycle later).
  - ADDRESS: on each SCLK rise, shift the synchronised MOSI into the 16-bit address register. After the 16th bit, go to DATA with the bit counter cleared.
  - DATA: on each SCLK rise, shift into the 8-bit data register. On the 8th bit, issue a write in the next cycle:
    - o_RegisterWriteEnable=1 for exactly one cycle, with o_RegisterNumber = current address and o_RegisterValue = assembled byte.
    - Clear the bit counter and stay in DATA.
    - If AUTO_INCREMENT=1, add 1 to the address after the write; 16'hFFFF wraps to 16'h0000.
- MISO: on each SCLK fall while in ADDRESS or DATA, shift the MISO register left, filling with 0. o_SpiMiso = register MSB, so sample bit 15 is presented from CS fall. After 16 bits, MISO outputs 0 for the rest of the frame.
- CS_N rise in any state: go to IDLE.
  - If rising in ADDRESS with at least 1 bit received, or in DATA with 1–7 bits received, increment o_FrameErrorCount (saturating) and write nothing.
  - A frame with zero SCLK edges, or one ending on a byte boundary in DATA, is not an error.
- CS_N rise in the same cycle as the 8th SCLK rise: the SCLK rise is processed first, so the write is issued and no error is counted.
- Latency: o_RegisterWriteEnable rises 2 i_Clock cycles after the synchronised SCLK rise edge of the last data bit. Worst case from the pin is SYNC_STAGES+2 cycles.
- Write strobes are at least 8 SCLK periods apart, so the synth core needs no back-pressure.

Test Plan:
- Single write: CS low, shift 24'hC0_05_7F, CS high -> exactly one o_RegisterWriteEnable pulse with Number=16'hC005, Value=8'h7F; o_FrameErrorCount stays 0.
- Burst with AUTO_INCREMENT=1: shift 16'h8000 then bytes 8'h01, 8'h02, 8'h03 -> three pulses at registers 8000/8001/8002 with values 01/02/03. Repeat at address 16'hFFFF -> second write goes to 16'h0000.
- Truncated frames: 10 bits, then 16+5 bits, then CS toggle with no clocks -> no writes issued; o_FrameErrorCount = 2. After 300 truncated frames -> o_FrameErrorCount = 8'hFF.
- Sample readout: pulse i_SampleReady with i_Sample=16'hA5C3, then run a 24-bit frame -> MISO bits 1010_0101_1100_0011 followed by 8 zeros. An i_SampleReady in the same cycle as CS fall -> the old value is shifted out.
- Reset mid-frame: assert i_Reset_n low after 12 bits, release with CS still low, clock 12 more bits -> no write, error count 0. Next complete frame after a CS high -> written normally.
- Timing: SCLK = i_Clock/8 with random phase -> every write strobe occurs 2 cycles after the synchronised 24th rise and is exactly 1 cycle wide.

Source files
------------

// File: rtl/spi_register_controller.sv
// SPI mode-0 slave that turns {16-bit register number, 8-bit values...} frames into
// single-cycle register writes, and shifts the last captured synth sample out on MISO.
module spi_register_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter bit AUTO_INCREMENT = 1'b1
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SpiSclk,
    input  logic        i_SpiMosi,
    input  logic        i_SpiCs_n,
    output logic        o_SpiMiso,
    input  logic [15:0] i_Sample,
    input  logic        i_SampleReady,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterNumber,
    output logic [7:0]  o_RegisterValue,
    output logic [7:0]  o_FrameErrorCount
);
    typedef enum logic [1:0] {IDLE, ADDRESS, DATA} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [15:0]            addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [15:0]            miso_q, miso_d;
    logic [15:0]            hold_q, hold_d;
    logic                   pend_q, pend_d;
    logic                   we_q, we_d;
    logic [15:0]            num_q, num_d;
    logic [7:0]             val_q, val_d;
    logic [7:0]             err_q, err_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // CS synchroniser resets low so a frame already in progress at reset release
    // cannot look like a fresh CS fall; the armed flag needs a real CS high first.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SpiSclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SpiMosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SpiCs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            armed_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            miso_q  <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            num_q   <= '0;
            val_q   <= '0;
            err_q   <= '0;
        end else begin
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            miso_q  <= miso_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            num_q   <= num_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        armed_d = armed_q | cs_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        miso_d  = miso_q;
        hold_d  = i_SampleReady ? i_Sample : hold_q;
        pend_d  = 1'b0;
        we_d    = pend_q;
        num_d   = num_q;
        val_d   = val_q;
        err_d   = err_q;

        // A byte completed last cycle: present it, then step the address.
        if (pend_q) begin
            num_d = addr_q;
            val_d = data_q;
            if (AUTO_INCREMENT) addr_d = addr_q + 16'd1;
        end

        if (state_q != IDLE && sclk_fall) miso_d = {miso_q[14:0], 1'b0};

        // The SCLK rise is applied before a coincident CS rise is judged.
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    miso_d  = hold_q;
                    cnt_d   = '0;
                    state_d = ADDRESS;
                end
            end
            ADDRESS: begin
                if (sclk_rise) begin
                    addr_d = {addr_q[14:0], mosi_s};
                    if (cnt_q == 5'd15) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_d != 5'd0 && err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    data_d = {data_q[6:0], mosi_s};
                    if (cnt_q == 5'd7) begin
                        cnt_d  = '0;
                        pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_d != 5'd0 && err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_SpiMiso             = miso_q[15];
    assign o_RegisterWriteEnable = we_q;
    assign o_RegisterNumber      = num_q;
    assign o_RegisterValue       = val_q;
    assign o_FrameErrorCount     = err_q;
endmodule

// File: tb/tb_spi_register_controller.sv
// Bench for spi_register_controller: table of write frames plus hand-written corner sequences.
module tb_spi_register_controller;
    logic        clk = 1'b0;
    logic        rst_n, sclk, mosi, cs_n, miso, rdy, we;
    logic [15:0] smp, num;
    logic [7:0]  val, errc;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [15:0] wnum[$];
    logic [7:0]  wval[$];
    int          wcyc[$];
    int          rc[64];

    spi_register_controller #(.SYNC_STAGES(2), .AUTO_INCREMENT(1'b1)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_SpiSclk(sclk), .i_SpiMosi(mosi),
        .i_SpiCs_n(cs_n), .o_SpiMiso(miso), .i_Sample(smp), .i_SampleReady(rdy),
        .o_RegisterWriteEnable(we), .o_RegisterNumber(num), .o_RegisterValue(val),
        .o_FrameErrorCount(errc)
    );

    initial forever begin
        @(posedge clk); #1;
        if (we) begin
            wnum.push_back(num);
            wval.push_back(val);
            wcyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        int d;
        repeat (n) @(posedge clk);
        d = $urandom_range(9, 1);
        #d;
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        @(posedge clk); #1;
        smp = v; rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
    endtask

    // With pulse set, i_SampleReady lands exactly on the cycle the CS fall is acted on.
    task automatic cs_low(input bit pulse, input logic [15:0] pv);
        tick(1);
        cs_n = 1'b0;
        repeat (2) @(posedge clk);
        if (pulse) begin
            #1; smp = pv; rdy = 1'b1;
        end
        @(posedge clk); #1;
        rdy = 1'b0;
        tick(1);
    endtask

    task automatic cs_high();
        tick(4);
        cs_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic spi_bit(input logic b, input bit end_cs, output logic m, output int rcy);
        tick(1);
        mosi = b;
        tick(3);
        m    = miso;
        sclk = 1'b1;
        rcy  = cyc;
        if (end_cs) cs_n = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [63:0] bits, input int n, input bit pulse,
                         input logic [15:0] pv, input bit simul, output logic [63:0] mo);
        logic m;
        int   r;
        mo = '0;
        wnum.delete(); wval.delete(); wcyc.delete();
        cs_low(pulse, pv);
        for (int i = 0; i < n; i++) begin
            spi_bit(bits[n-1-i], simul && (i == n - 1), m, r);
            mo    = {mo[62:0], m};
            rc[i] = r;
        end
        if (simul) repeat (10) @(posedge clk);
        else cs_high();
    endtask

    task automatic chk_writes(input logic [15:0] a, input int nb, input logic [23:0] dat);
        logic [15:0] ea;
        logic [7:0]  ev;
        chk("wr_count", 64'(wnum.size()), 64'(nb));
        for (int i = 0; i < nb && i < wnum.size(); i++) begin
            ea = a + 16'(i);
            ev = dat[23-8*i -: 8];
            chk("wr_num", 64'(wnum[i]), 64'(ea));
            chk("wr_val", 64'(wval[i]), 64'(ev));
            chk("wr_latency", 64'(wcyc[i] - rc[23+8*i]), 64'd4);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        int          nb;
        logic [23:0] dat;
        logic [15:0] smp;
        logic [15:0] last_num;
    } vec_t;

    vec_t        tbl[5];
    logic [63:0] mo, bits;
    int          n;

    initial begin
        tbl[0] = '{16'hC005, 1, 24'h7F0000, 16'hA5C3, 16'hC005};
        tbl[1] = '{16'h8000, 3, 24'h010203, 16'h1234, 16'h8002};
        tbl[2] = '{16'hFFFF, 2, 24'hAA5500, 16'h8001, 16'h0000};
        tbl[3] = '{16'h0000, 1, 24'h000000, 16'hFFFF, 16'h0000};
        tbl[4] = '{16'h1234, 1, 24'hFF0000, 16'h0000, 16'h1234};

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rdy = 1'b0; smp = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_num", 64'(num), 64'd0);
        chk("rst_val", 64'(val), 64'd0);
        chk("rst_err", 64'(errc), 64'd0);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            pulse_sample(tbl[v].smp);
            n    = 16 + 8 * tbl[v].nb;
            bits = 64'({tbl[v].addr, tbl[v].dat}) >> (8 * (3 - tbl[v].nb));
            frame(bits, n, 1'b0, 16'h0, 1'b0, mo);
            chk_writes(tbl[v].addr, tbl[v].nb, tbl[v].dat);
            if (wnum.size() == tbl[v].nb)
                chk("last_num", 64'(wnum[tbl[v].nb-1]), 64'(tbl[v].last_num));
            chk("miso", mo, 64'(tbl[v].smp) << (n - 16));
            chk("err_tbl", 64'(errc), 64'd0);
        end

        // CS rise coincident with the final SCLK rise still writes, no error.
        frame(64'h5A5A3C, 24, 1'b0, 16'h0, 1'b1, mo);
        chk_writes(16'h5A5A, 1, 24'h3C0000);
        chk("err_simul", 64'(errc), 64'd0);
        chk("miso_simul", mo, 64'd0);

        // Sample strobe on the CS-fall cycle: old value goes out, new one next frame.
        pulse_sample(16'h1111);
        frame(64'h010111, 24, 1'b1, 16'h2222, 1'b0, mo);
        chk("miso_old", mo, 64'h111100);
        chk_writes(16'h0101, 1, 24'h110000);
        frame(64'h010222, 24, 1'b0, 16'h0, 1'b0, mo);
        chk("miso_new", mo, 64'h222200);

        frame(64'h2AB, 10, 1'b0, 16'h0, 1'b0, mo);
        chk("trunc10_wr", 64'(wnum.size()), 64'd0);
        chk("trunc10_err", 64'(errc), 64'd1);
        frame(64'h12345, 21, 1'b0, 16'h0, 1'b0, mo);
        chk("trunc21_wr", 64'(wnum.size()), 64'd0);
        chk("trunc21_err", 64'(errc), 64'd2);
        frame(64'h0, 0, 1'b0, 16'h0, 1'b0, mo);
        chk("noclk_wr", 64'(wnum.size()), 64'd0);
        chk("noclk_err", 64'(errc), 64'd2);

        for (int i = 0; i < 252; i++) frame(64'h1, 1, 1'b0, 16'h0, 1'b0, mo);
        chk("err_254", 64'(errc), 64'hFE);
        for (int i = 0; i < 48; i++) frame(64'h1, 1, 1'b0, 16'h0, 1'b0, mo);
        chk("err_sat", 64'(errc), 64'hFF);

        // Reset in the middle of a frame; the rest of that frame must be ignored.
        begin
            logic m;
            int   r;
            wnum.delete(); wval.delete(); wcyc.delete();
            cs_low(1'b0, 16'h0);
            for (int i = 0; i < 12; i++) spi_bit(1'b1, 1'b0, m, r);
            @(posedge clk); #3 rst_n = 1'b0;
            repeat (2) @(posedge clk); #3 rst_n = 1'b1;
            #1 chk("err_after_rst", 64'(errc), 64'd0);
            for (int i = 0; i < 12; i++) spi_bit(i[0], 1'b0, m, r);
            cs_high();
            chk("rstmid_wr", 64'(wnum.size()), 64'd0);
            chk("rstmid_err", 64'(errc), 64'd0);
        end
        frame(64'h424299, 24, 1'b0, 16'h0, 1'b0, mo);
        chk_writes(16'h4242, 1, 24'h990000);
        chk("miso_after_rst", mo, 64'd0);
        chk("err_final", 64'(errc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
